// File: rtl/cpu_bp_pkg.sv
// Shared branch-predictor definitions: counter constants and direction encoding.
package cpu_bp_pkg;

    typedef enum logic {
        CtrDec = 1'b0,
        CtrInc = 1'b1
    } ctr_dir_e;

    // Weakly not-taken: just below the MSB boundary.
    function automatic int unsigned wnt_val(input int unsigned ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned wt_val(input int unsigned ctr_w);
        return 32'd1 << (ctr_w - 1);
    endfunction

endpackage

// File: rtl/sat_counter_next.sv
// Next-state of a saturating up/down direction counter; never wraps.
module sat_counter_next
    import cpu_bp_pkg::*;
#(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             taken,
    output logic [CTR_W-1:0] ctr_next
);

    localparam logic [CTR_W-1:0] One = CTR_W'(1);

    ctr_dir_e dir;

    assign dir = taken ? CtrInc : CtrDec;

    always_comb begin
        ctr_next = ctr;
        unique case (dir)
            CtrInc: if (ctr != '1) ctr_next = ctr + One;
            CtrDec: if (ctr != '0) ctr_next = ctr - One;
            default: ctr_next = ctr;
        endcase
    end

endmodule

// File: rtl/branch_counter_table.sv
// Bimodal/gshare direction predictor: flop array of saturating counters plus
// speculative and architectural global history.
module branch_counter_table
    import cpu_bp_pkg::*;
#(
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned GHR_W   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [INDEX_W-1:0] req_pc_index,
    input  logic               req_miss,
    output logic               pred_taken,
    output logic               pred_strong,
    output logic [INDEX_W-1:0] pred_index,
    input  logic               install_en,
    input  logic [INDEX_W-1:0] install_index,
    input  logic               install_hint,
    input  logic               update_en,
    input  logic [INDEX_W-1:0] update_index,
    input  logic               update_taken,
    input  logic               update_mispredict
);

    localparam int unsigned Depth = 2 ** INDEX_W;
    localparam logic [CTR_W-1:0] Wnt = CTR_W'(wnt_val(CTR_W));
    localparam logic [CTR_W-1:0] Wt  = CTR_W'(wt_val(CTR_W));

    logic [CTR_W-1:0] ctr_q [Depth];
    logic [CTR_W-1:0] rd_ctr;
    logic [CTR_W-1:0] upd_next;

    sat_counter_next #(
        .CTR_W (CTR_W)
    ) u_upd_next (
        .ctr      (ctr_q[update_index]),
        .taken    (update_taken),
        .ctr_next (upd_next)
    );

    // Install is written last so it wins on an index collision with update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) ctr_q[i] <= Wnt;
        end else begin
            if (update_en) ctr_q[update_index] <= upd_next;
            if (install_en) ctr_q[install_index] <= install_hint ? Wt : Wnt;
        end
    end

    assign rd_ctr      = ctr_q[pred_index];
    assign pred_taken  = ~req_miss & rd_ctr[CTR_W-1];
    assign pred_strong = ~req_miss & ((rd_ctr == '0) | (rd_ctr == '1));

    if (GHR_W > 0) begin : g_gshare
        logic [GHR_W-1:0] ghr_spec_q, ghr_spec_d;
        logic [GHR_W-1:0] ghr_arch_q, ghr_arch_d;

        assign pred_index = req_pc_index ^ INDEX_W'(ghr_spec_q);

        always_comb begin
            ghr_arch_d = ghr_arch_q;
            if (update_en) ghr_arch_d = (ghr_arch_q << 1) | GHR_W'(update_taken);
        end

        // Mispredict recovery overrides any same-cycle speculative shift.
        always_comb begin
            ghr_spec_d = ghr_spec_q;
            if (update_en && update_mispredict) begin
                ghr_spec_d = ghr_arch_d;
            end else if (req_valid && !req_miss) begin
                ghr_spec_d = (ghr_spec_q << 1) | GHR_W'(pred_taken);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                ghr_spec_q <= '0;
                ghr_arch_q <= '0;
            end else begin
                ghr_spec_q <= ghr_spec_d;
                ghr_arch_q <= ghr_arch_d;
            end
        end
    end else begin : g_bimodal
        logic unused_ghr_inputs;

        assign pred_index        = req_pc_index;
        assign unused_ghr_inputs = ^{req_valid, update_mispredict};
    end

endmodule

// File: tb/tb_branch_counter_table.sv
// Directed bench for branch_counter_table: a gshare instance (CTR_W=2, GHR_W=4)
// and a bimodal instance (CTR_W=3) share stimulus and are checked against a model.
module tb_branch_counter_table;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_miss;
    logic [3:0] req_pc_index;
    logic       install_en, install_hint;
    logic [3:0] install_index;
    logic       update_en, update_taken, update_mispredict;
    logic [3:0] update_index;

    logic       a_taken, a_strong, b_taken, b_strong;
    logic [3:0] a_index, b_index;

    int checks   = 0;
    int failures = 0;

    // Reference state: counters as plain integers, history as masked integers.
    int ma [16];
    int mb [16];
    int gs, ga;

    typedef struct {
        string      tag;
        logic       a_t, a_s;
        logic [3:0] a_i;
        logic       b_t, b_s;
        logic [3:0] b_i;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    branch_counter_table #(.INDEX_W(4), .CTR_W(2), .GHR_W(4)) dut_a (
        .clk (clk), .reset (reset), .req_valid (req_valid), .req_pc_index (req_pc_index),
        .req_miss (req_miss), .pred_taken (a_taken), .pred_strong (a_strong),
        .pred_index (a_index), .install_en (install_en), .install_index (install_index),
        .install_hint (install_hint), .update_en (update_en), .update_index (update_index),
        .update_taken (update_taken), .update_mispredict (update_mispredict)
    );

    branch_counter_table #(.INDEX_W(4), .CTR_W(3), .GHR_W(0)) dut_b (
        .clk (clk), .reset (reset), .req_valid (req_valid), .req_pc_index (req_pc_index),
        .req_miss (req_miss), .pred_taken (b_taken), .pred_strong (b_strong),
        .pred_index (b_index), .install_en (install_en), .install_index (install_index),
        .install_hint (install_hint), .update_en (update_en), .update_index (update_index),
        .update_taken (update_taken), .update_mispredict (update_mispredict)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input logic up, input int max);
        if (up) return (v < max) ? v + 1 : max;
        return (v > 0) ? v - 1 : 0;
    endfunction

    task automatic model_edge();
        int ia, nga;
        logic pt;
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                ma[i] = 1;
                mb[i] = 3;
            end
            gs = 0;
            ga = 0;
        end else begin
            ia  = (int'(req_pc_index) ^ gs) & 15;
            pt  = !req_miss && (ma[ia] >= 2);
            nga = ga;
            if (update_en) begin
                ma[update_index] = sat(ma[update_index], update_taken, 3);
                mb[update_index] = sat(mb[update_index], update_taken, 7);
                nga = ((ga << 1) | int'(update_taken)) & 15;
            end
            if (install_en) begin
                ma[install_index] = install_hint ? 2 : 1;
                mb[install_index] = install_hint ? 4 : 3;
            end
            if (update_en && update_mispredict) gs = nga;
            else if (req_valid && !req_miss) gs = ((gs << 1) | int'(pt)) & 15;
            ga = nga;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        reset = 0; req_valid = 0; req_miss = 0;
        install_en = 0; update_en = 0; update_mispredict = 0;
    endtask

    // Push the model's expectation for the current inputs, then compare once settled.
    task automatic check_pred(input string tag);
        exp_t e, got;
        int ia, ca, cb;
        ia = (int'(req_pc_index) ^ gs) & 15;
        ca = ma[ia];
        cb = mb[req_pc_index];
        e.tag = tag;
        e.a_i = 4'(ia);
        e.a_t = !req_miss && (ca >= 2);
        e.a_s = !req_miss && (ca == 0 || ca == 3);
        e.b_i = req_pc_index;
        e.b_t = !req_miss && (cb >= 4);
        e.b_s = !req_miss && (cb == 0 || cb == 7);
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        chk({got.tag, ".a_taken"},  4'(a_taken),  4'(got.a_t));
        chk({got.tag, ".a_strong"}, 4'(a_strong), 4'(got.a_s));
        chk({got.tag, ".a_index"},  a_index,      got.a_i);
        chk({got.tag, ".b_taken"},  4'(b_taken),  4'(got.b_t));
        chk({got.tag, ".b_strong"}, 4'(b_strong), 4'(got.b_s));
        chk({got.tag, ".b_index"},  b_index,      got.b_i);
    endtask

    task automatic do_update(input logic [3:0] idx, input logic tk);
        update_en = 1; update_index = idx; update_taken = tk; update_mispredict = 0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; req_valid = 0; req_miss = 0; req_pc_index = 0;
        install_en = 0; install_index = 0; install_hint = 0;
        update_en = 0; update_index = 0; update_taken = 0; update_mispredict = 0;
        tick();
        reset = 1;
        tick();

        req_pc_index = 4'd5;
        check_pred("reset_idx5");
        chk("reset_a_taken_const", 4'(a_taken), 4'd0);

        for (int i = 0; i < 4; i++) begin
            do_update(4'd5, 1'b1);
            req_pc_index = 4'd5;
            check_pred($sformatf("inc5_%0d", i));
        end
        chk("sat_taken_const", 4'(a_taken), 4'd1);
        chk("sat_strong_const", 4'(a_strong), 4'd1);
        do_update(4'd5, 1'b1);
        req_pc_index = 4'd5;
        check_pred("inc5_saturate");

        install_en = 1; install_index = 4'd2; install_hint = 1;
        tick();
        req_pc_index = 4'd2;
        check_pred("install2_hint1");
        chk("b_install_wt_const", 4'(b_taken), 4'd1);
        do_update(4'd2, 1'b0);
        req_pc_index = 4'd2;
        check_pred("dec2");
        chk("b_dec_wnt_const", 4'(b_taken), 4'd0);

        install_en = 1; install_index = 4'd7; install_hint = 0;
        update_en = 1; update_index = 4'd7; update_taken = 1;
        tick();
        req_pc_index = 4'd7;
        check_pred("collide7_install_wins");

        install_en = 1; install_index = 4'd7; install_hint = 0;
        update_en = 1; update_index = 4'd8; update_taken = 1;
        tick();
        req_pc_index = 4'd8;
        check_pred("split8_update");
        chk("split8_a_taken_const", 4'(a_taken), 4'd1);
        req_pc_index = 4'd7;
        check_pred("split7_install");

        // History section starts from a clean table so ghr_arch is zero.
        reset = 1;
        tick();
        install_en = 1; install_index = 4'd5; install_hint = 1;
        tick();
        req_valid = 1; req_pc_index = 4'd5;
        check_pred("fire1");
        tick();
        req_valid = 1; req_pc_index = 4'd4;
        check_pred("fire2");
        tick();
        req_valid = 1; req_pc_index = 4'd0;
        check_pred("fire3");
        tick();
        req_pc_index = 4'd0;
        check_pred("ghr_after_fires");
        chk("ghr_spec_0110_const", a_index, 4'h6);

        req_valid = 1; req_miss = 1; req_pc_index = 4'd3;
        check_pred("miss_forces_nt");
        tick();
        req_pc_index = 4'd0;
        check_pred("ghr_after_miss");

        req_valid = 1; req_pc_index = 4'd0;
        update_en = 1; update_index = 4'd9; update_taken = 1; update_mispredict = 1;
        tick();
        req_pc_index = 4'd0;
        check_pred("mispredict_restore");
        chk("ghr_spec_0001_const", a_index, 4'h1);

        reset = 1;
        install_en = 1; install_index = 4'd3; install_hint = 1;
        update_en = 1; update_index = 4'd3; update_taken = 1;
        tick();
        req_pc_index = 4'd3;
        check_pred("reset_beats_install");
        update_en = 1; update_index = 4'd1; update_taken = 0; update_mispredict = 1;
        tick();
        req_pc_index = 4'd0;
        check_pred("ghr_arch_cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
